// File: rtl/apb_slave_mem_pkg.sv
// Shared types and helpers for the APB completer memory.
// No logic: state encoding and strobe-width helper only.
// Imported by apb_slave_mem and apb_slave_mem_array.
package apb_slave_mem_pkg;

  // Completer FSM: waiting for a setup phase, or inside the access phase.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_t;

  // Number of byte lanes on a data bus of the given width.
  function automatic int apb_strb_w(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_slave_mem_array.sv
// DEPTH x DATA_WIDTH storage, byte-strobe write port, registered read port.
// Latency: write visible the cycle after we; rdata valid the cycle after re.
// Backpressure: none; caller guarantees a write and a read never coincide.
module apb_slave_mem_array
  import apb_slave_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int STRB_W     = apb_strb_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  re,
  input  logic [IDX_W-1:0]      ridx,
  input  logic                  rzero,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Next memory image: only lanes with a set strobe take the new byte.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_d[widx][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data register: loads on a read request, otherwise holds.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rzero ? '0 : mem_q[ridx];
    end
  end

  // Storage and read register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer in front of a word-addressed memory, with wait states and error response.
// Latency: wait_cfg=N gives N+1 access cycles; pready comes only from registers.
// Backpressure: holds pready low while the latched wait count runs down.
module apb_slave_mem
  import apb_slave_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    WAIT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  input  logic [WAIT_W-1:0]       wait_cfg,
  output logic                    proto_err
);

  localparam int STRB_W    = apb_strb_w(DATA_WIDTH);
  localparam int OFF_W     = $clog2(STRB_W);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int MEM_BYTES = DEPTH * STRB_W;

  apb_slv_state_t        state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic                  proto_err_q, proto_err_d;

  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH:0]   off;
  logic                  dec_err;
  logic [IDX_W-1:0]      dec_idx;

  // Setup-phase decode; the extra top bit of off catches addresses below the base.
  assign off     = {1'b0, paddr} - {1'b0, BASE_ADDR};
  assign dec_err = off[ADDR_WIDTH]
                || (off >= (ADDR_WIDTH+1)'(MEM_BYTES))
                || (paddr[OFF_W-1:0] != '0);
  assign dec_idx = off[OFF_W +: IDX_W];

  // Outputs come from registered state only, never from bus inputs.
  assign pready    = (state_q == ACCESS) && (cnt_q == '0);
  assign pslverr   = pready && err_q;
  assign proto_err = proto_err_q;

  // FSM: latch the request in setup, count wait states, complete or abort in access.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    idx_d       = idx_q;
    write_d     = write_q;
    err_d       = err_q;
    proto_err_d = proto_err_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          wdata_d = pwdata;
          strb_d  = pstrb;
          write_d = pwrite;
          idx_d   = dec_idx;
          err_d   = dec_err;
          cnt_d   = wait_cfg;
          mem_re  = !pwrite;
          state_d = ACCESS;
        end else if (psel && penable) begin
          // Enable without a preceding setup: flag it and otherwise ignore.
          proto_err_d = 1'b1;
        end
      end
      ACCESS: begin
        if (!psel || !penable) begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          // Request fields must stay stable; a change is flagged but the latched copy wins.
          if ((paddr != addr_q) || (pwrite != write_q) || (pwdata != wdata_q)) begin
            proto_err_d = 1'b1;
          end
          if (cnt_q != '0) begin
            cnt_d = cnt_q - WAIT_W'(1);
          end else begin
            mem_we  = write_q && !err_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      err_q       <= err_d;
      proto_err_q <= proto_err_d;
    end
  end

  apb_slave_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W),
    .STRB_W     (STRB_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .re    (mem_re),
    .ridx  (dec_idx),
    .rzero (dec_err),
    .rdata (prdata)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized self-checking bench for apb_slave_mem against a word-array model.
// Transfers run back-to-back; timing, error and data are checked per transfer.
// Protocol abort, field change, idle-enable and reset-in-access scenarios included.
module tb_apb_slave_mem;

  localparam int          DEPTH     = 256;
  localparam logic [31:0] BASE      = 32'h0000_4000;
  localparam logic [31:0] MEM_BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb, wait_cfg;
  logic        pready, pslverr, proto_err;

  logic [31:0] model [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  apb_slave_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE),
    .WAIT_W     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .wait_cfg  (wait_cfg),
    .proto_err (proto_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; wait_cfg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  // Let the completion edge pass, then release the bus.
  task automatic apb_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // One transfer. mode 0: legal; 1: drop psel in 2nd access cycle; 2: change paddr in 2nd access cycle.
  // Returns at the falling edge of the pready cycle so the next call is a bubble-free setup.
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int nwait, input int mode);
    bit          exp_err, done;
    logic [31:0] exp_rd;
    int          idx, cyc;
    exp_err = (addr < BASE) || (addr >= BASE + MEM_BYTES) || (addr % 4 != 0);
    idx     = exp_err ? 0 : int'((addr - BASE) / 4);
    exp_rd  = exp_err ? 32'h0 : model[idx];
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = data; pstrb = strb; wait_cfg = 4'(nwait);
    @(posedge clk); #1;
    penable  = 1'b1;
    wait_cfg = 4'($urandom);
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc <= 40) begin
      if (mode == 1 && cyc == 2) begin psel = 1'b0; penable = 1'b0; end
      if (mode == 2 && cyc == 2) paddr = addr ^ 32'h4;
      @(negedge clk);
      if (mode == 1 && cyc == 2) done = 1'b1;
      else if (pready) done = 1'b1;
      else begin
        cyc++;
        @(posedge clk); #1;
      end
    end
    if (!done) check_eq("timeout", 64'd1, 64'd0);
    else if (mode != 1) begin
      check_eq("latency", 64'(cyc), 64'(nwait + 1));
      check_eq("pslverr", 64'(pslverr), 64'(exp_err));
      if (!wr) check_eq("prdata", 64'(prdata), 64'(exp_rd));
      if (wr && !exp_err) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      return BASE + MEM_BYTES + 32'($urandom_range(0, 255)) * 4;
    else if (r == 1) return BASE - 32'($urandom_range(1, 64)) * 4;
    else if (r == 2) return BASE + 32'($urandom_range(0, DEPTH-1)) * 4 + 32'($urandom_range(1, 3));
    else if (r < 6)  return BASE + 32'($urandom_range(0, 15)) * 4;
    else             return BASE + 32'($urandom_range(0, DEPTH-1)) * 4;
  endfunction

  initial begin
    do_reset();
    @(negedge clk);
    check_eq("rst_pready", 64'(pready), 64'd0);
    check_eq("rst_pslverr", 64'(pslverr), 64'd0);
    check_eq("rst_prdata", 64'(prdata), 64'd0);
    check_eq("rst_proto_err", 64'(proto_err), 64'd0);

    // Directed: zero-wait, wait states, strobes, error responses.
    apb_xfer(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    apb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'h0, 0, 0);
    apb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'h0, 3, 0);
    check_eq("wait_rd", 64'(prdata), 64'hDEADBEEF);
    apb_xfer(1'b1, BASE + 32'h10, 32'h11223344, 4'b0101, 1, 0);
    apb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'h0, 0, 0);
    check_eq("strb_rd", 64'(prdata), 64'hDE22BE44);
    apb_xfer(1'b1, BASE + MEM_BYTES, 32'hCAFEF00D, 4'hF, 0, 0);
    apb_xfer(1'b0, BASE + 32'h2, 32'h0, 4'h0, 2, 0);
    check_eq("misal_rd", 64'(prdata), 64'h0);
    apb_xfer(1'b0, BASE, 32'h0, 4'h0, 0, 0);
    apb_idle();

    // Randomized back-to-back traffic.
    for (int i = 0; i < 200; i++) begin
      apb_xfer(1'($urandom), rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3), 0);
      if ($urandom_range(0, 3) == 0) apb_idle();
    end
    apb_idle();
    @(negedge clk);
    check_eq("proto_clean", 64'(proto_err), 64'd0);

    // Abort: psel dropped in the 2nd access cycle of a 5-wait write.
    apb_xfer(1'b1, BASE + 32'h10, 32'h55AA55AA, 4'hF, 5, 1);
    @(posedge clk); #1;
    check_eq("abort_proto", 64'(proto_err), 64'd1);
    check_eq("abort_pready", 64'(pready), 64'd0);
    apb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'h0, 1, 0);
    apb_idle();
    @(negedge clk);
    check_eq("proto_sticky", 64'(proto_err), 64'd1);

    // Reset in the middle of a wait-stated write.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h20;
    pwdata = 32'h12345678; pstrb = 4'hF; wait_cfg = 4'd6;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_pready", 64'(pready), 64'd0);
    check_eq("midrst_prdata", 64'(prdata), 64'd0);
    check_eq("midrst_proto", 64'(proto_err), 64'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < DEPTH; i++) apb_xfer(1'b0, BASE + 32'(i) * 4, 32'h0, 4'h0, 0, 0);
    apb_idle();

    // Enable without setup while idle.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    check_eq("idle_en_proto", 64'(proto_err), 64'd1);
    check_eq("idle_en_pready", 64'(pready), 64'd0);

    // Address change mid-access: flagged, but completes with latched values.
    do_reset();
    apb_xfer(1'b1, BASE + 32'h30, 32'hA5A5F00F, 4'hF, 2, 2);
    apb_idle();
    check_eq("chg_proto", 64'(proto_err), 64'd1);
    apb_xfer(1'b0, BASE + 32'h30, 32'h0, 4'h0, 0, 0);
    apb_xfer(1'b0, BASE + 32'h34, 32'h0, 4'h0, 0, 0);
    apb_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- Synthesizable APB4 completer: word-addressed memory with programmable wait states, byte strobes and error response.
- Sits at the far end of the bridge's APB master port, as the completer for bridge-level simulation and FPGA bring-up.
- Provides a real target so AXI-to-APB read/write paths close end-to-end.

Parameters:
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 32 or 64.
- DEPTH, 256, number of DATA_WIDTH words; power of two.
- BASE_ADDR, 32'h0000_0000, first valid byte address; must be DEPTH*DATA_WIDTH/8 aligned.
- WAIT_W, 4, width of wait_cfg.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte strobes.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  access complete.
- pslverr  out  1  error response, valid only with pready.
- wait_cfg  in  WAIT_W  wait states inserted per access; sampled in setup.
- proto_err  out  1  sticky flag for an APB protocol violation by the requester.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; prdata=0, pready=0, pslverr=0, proto_err=0.
  - Wait counter = 0; all memory words = 0.
- States: IDLE, ACCESS.
- IDLE:
  - On edge with psel=1 & penable=0 (setup), latch paddr/pwrite/pwdata/pstrb and load cnt=wait_cfg. Go to ACCESS.
  - Decode at setup. err = paddr outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_WIDTH/8), or paddr low log2(DATA_WIDTH/8) bits nonzero.
  - Read with no error: prdata <= mem[index]. Read with error: prdata <= 0. prdata holds until the next read setup.
- ACCESS:
  - pready = (state==ACCESS) && (cnt==0). pready is driven from registers only; there is no combinational path from inputs.
  - pslverr = pready && err_latched.
  - cnt != 0: decrement by 1 per cycle.
  - cnt == 0 and psel & penable sampled: complete. Write with no error: mem[index] byte lane i <= pwdata lane i where pstrb[i]=1. Go to IDLE.
- Latency: wait_cfg=N gives N+1 access-phase cycles; pready is high in the (N+1)th. N=0 gives a zero-wait APB transfer.
- Back-to-back: the cycle after completion is in IDLE. If psel=1 & penable=0 there, it is a new setup with no bubble.
- Read on write, error write: memory unchanged.
- Protocol violations, detected in ACCESS:
  - psel=0 or penable=0 → proto_err <= 1, abort to IDLE, memory untouched.
  - paddr/pwrite/pwdata changed versus the latched value → proto_err <= 1; the transfer still completes using the latched values.
  - proto_err clears only on reset.
- In IDLE: psel=1 & penable=1 with no prior setup → proto_err <= 1, ignored.
- wait_cfg changes mid-access: no effect on the current transfer.
- Reset mid-ACCESS: immediate return to IDLE, pending write dropped, memory zeroed.
- Index = (paddr - BASE_ADDR) >> log2(DATA_WIDTH/8), truncated to log2(DEPTH) bits after the range check.

Decomposition:
- bridge_utils package gains:
  - apb_slv_state_t enum {IDLE, ACCESS}.
  - APB_STRB_W localparam function (DATA_WIDTH/8).
- One sub-module: apb_slave_mem_array.
  - DEPTH x DATA_WIDTH storage with async-reset clear.
  - Byte-strobe write port and registered read port.
  - FSM, decode and protocol checks stay in apb_slave_mem.

Test Plan:
- Zero-wait write/read: wait_cfg=0, write 0xDEADBEEF to BASE+0x10 with pstrb=4'hF, then read BASE+0x10 → pready in first access cycle both times, prdata=0xDEADBEEF, pslverr=0.
- Wait states: wait_cfg=3, read BASE+0x10 → pready low 3 access cycles, high on 4th, prdata=0xDEADBEEF.
- Byte strobes: write 0x11223344 to BASE+0x10 with pstrb=4'b0101 → readback 0xDE22BE44.
- Errors:
  - Write to BASE+DEPTH*4 → pready with pslverr=1, memory unchanged.
  - Read of BASE+0x2 (misaligned) → pslverr=1, prdata=0.
- Protocol abort: wait_cfg=5, drop psel in 2nd access cycle → proto_err=1 sticky, target word unchanged. Next legal transfer completes normally.
- Reset mid-ACCESS: assert rst_n=0 during a wait-stated write → pready=0, state IDLE, all words read back 0 after reset release.
